// File: rtl/sm_addsub_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sm_addsub_pkg
// Brief   : Shared types and helpers for the digit-serial sign-magnitude adder
// Revision: 1.0
// ============================================================================
package sm_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic MODE_UNSIGNED = 1'b0;
   localparam logic MODE_SIGNED   = 1'b1;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sm_addsub_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : sm_addsub_seq_if
// Brief   : Start/result handshake bundle of the sequential adder/subtractor
// Revision: 1.0
// ============================================================================
interface sm_addsub_seq_if #(
   parameter int WIDTH = 8
);
   logic             iStart;
   logic             iSA;
   logic             iSub;
   logic [WIDTH-1:0] iData_a;
   logic [WIDTH-1:0] iData_b;
   logic [WIDTH:0]   oData;
   logic             oData_C;
   logic             oBusy;
   logic             oDone;

   modport master (
      output iStart, iSA, iSub, iData_a, iData_b,
      input  oData, oData_C, oBusy, oDone
   );

   modport slave (
      input  iStart, iSA, iSub, iData_a, iData_b,
      output oData, oData_C, oBusy, oDone
   );
endinterface
`default_nettype wire

// File: rtl/sm_digit_addsub.sv
`default_nettype none
// ============================================================================
// Module  : sm_digit_addsub
// Brief   : Combinational DIGIT-bit slice adder with optional inversion of b
// Revision: 1.0
// ============================================================================
module sm_digit_addsub #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] iA,
   input  logic [DIGIT-1:0] iB,
   input  logic             iInvB,
   input  logic             iCarry,
   output logic [DIGIT-1:0] oSum,
   output logic             oCarry
);
   logic [DIGIT-1:0] w_b;

   assign w_b = iInvB ? ~iB : iB;
   assign {oCarry, oSum} = {1'b0, iA} + {1'b0, w_b} + {{DIGIT{1'b0}}, iCarry};
endmodule
`default_nettype wire

// File: rtl/sm_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module  : sm_addsub_seq
// Brief   : Digit-serial unsigned / sign-magnitude adder-subtractor, fixed latency
// Revision: 1.0
// ============================================================================
module sm_addsub_seq #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic               iClk,
   input  logic               iRst,
   sm_addsub_seq_if.slave     bus
);
   import sm_addsub_pkg::*;

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? clog2(N) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

   generate
      if (((WIDTH % DIGIT) != 0) || (WIDTH < 2)) begin : g_badParams
         $error("sm_addsub_seq: WIDTH must be >= 2 and a multiple of DIGIT");
      end
   endgenerate

   state_t             r_state;
   state_t             w_nextState;
   logic               w_busy;
   logic               w_done;
   logic               w_accept;
   logic               w_effSub;

   logic               r_sa;
   logic               r_effSub;
   logic               r_signA;
   logic               r_signB;
   logic [WIDTH-1:0]   r_ma;
   logic [WIDTH-1:0]   r_mb;
   logic [WIDTH-1:0]   r_raw;
   logic               r_carry;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH:0]     r_data;
   logic               r_dataC;

   logic [DIGIT-1:0]       w_sum;
   logic                   w_carryOut;
   logic [WIDTH+DIGIT-1:0] w_rawCat;
   logic [WIDTH-1:0]       w_negRaw;
   logic [WIDTH-1:0]       w_mag;
   logic                   w_sign;
   logic [WIDTH:0]         w_fixData;
   logic                   w_fixC;

   assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && bus.iStart;
   // Signed mode subtracts magnitudes whenever the effective signs differ
   assign w_effSub = (bus.iSA == MODE_SIGNED)
                   ? (bus.iData_a[WIDTH-1] != (bus.iData_b[WIDTH-1] ^ bus.iSub))
                   : bus.iSub;

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) r_state <= IDLE;
      else      r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: if (bus.iStart) w_nextState = CALC;
         CALC: begin
            w_busy = 1'b1;
            if (r_cnt == C_LAST) w_nextState = FIX;
         end
         FIX: begin
            w_busy      = 1'b1;
            w_nextState = DONE;
         end
         DONE: begin
            w_done      = 1'b1;
            w_nextState = bus.iStart ? CALC : IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   sm_digit_addsub #(.DIGIT(DIGIT)) u_digit (
      .iA     (r_ma[DIGIT-1:0]),
      .iB     (r_mb[DIGIT-1:0]),
      .iInvB  (r_effSub),
      .iCarry (r_carry),
      .oSum   (w_sum),
      .oCarry (w_carryOut)
   );

   assign w_rawCat = {w_sum, r_raw};
   assign w_negRaw = WIDTH'(0) - r_raw;

   always_comb begin
      w_mag     = r_raw;
      w_sign    = 1'b0;
      w_fixC    = 1'b0;
      w_fixData = '0;
      if (r_sa == MODE_UNSIGNED) begin
         if (r_effSub) begin
            w_fixC    = ~r_carry;
            w_fixData = {~r_carry, r_raw};
         end else begin
            w_fixC    = r_carry;
            w_fixData = {r_carry, r_raw};
         end
      end else begin
         if (!r_effSub) begin
            w_sign = r_signA;
            w_fixC = r_raw[WIDTH-1];
         end else if (!r_carry) begin
            w_mag  = w_negRaw;
            w_sign = r_signB;
         end else begin
            w_sign = r_signA;
         end
         // A zero magnitude never carries a negative sign
         if (w_mag == '0) w_sign = 1'b0;
         w_fixData = {w_sign, w_mag};
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_sa     <= 1'b0;
         r_effSub <= 1'b0;
         r_signA  <= 1'b0;
         r_signB  <= 1'b0;
         r_ma     <= '0;
         r_mb     <= '0;
         r_raw    <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_data   <= '0;
         r_dataC  <= 1'b0;
      end else if (w_accept) begin
         r_sa     <= bus.iSA;
         r_effSub <= w_effSub;
         r_signA  <= bus.iData_a[WIDTH-1];
         r_signB  <= bus.iData_b[WIDTH-1] ^ bus.iSub;
         r_ma     <= (bus.iSA == MODE_SIGNED) ? {1'b0, bus.iData_a[WIDTH-2:0]} : bus.iData_a;
         r_mb     <= (bus.iSA == MODE_SIGNED) ? {1'b0, bus.iData_b[WIDTH-2:0]} : bus.iData_b;
         r_raw    <= '0;
         r_carry  <= w_effSub;
         r_cnt    <= '0;
      end else if (r_state == CALC) begin
         r_ma    <= r_ma >> DIGIT;
         r_mb    <= r_mb >> DIGIT;
         r_raw   <= w_rawCat[WIDTH+DIGIT-1:DIGIT];
         r_carry <= w_carryOut;
         r_cnt   <= (r_cnt == C_LAST) ? '0 : r_cnt + CNT_W'(1);
      end else if (r_state == FIX) begin
         r_data  <= w_fixData;
         r_dataC <= w_fixC;
      end
   end

   assign bus.oData   = r_data;
   assign bus.oData_C = r_dataC;
   assign bus.oBusy   = w_busy;
   assign bus.oDone   = w_done;
endmodule
`default_nettype wire
